// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, NOP word and fetch-responder state encoding.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 program store: synchronous write, registered read, read-before-write on collision.
module imem_array
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] rdata_q;

  always_ff @(posedge clock_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Storage is not reset; only the read register is, so the response word starts at zero.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory responder: fixed wait-state latency, error flagging and flush.
module imem_responder
  import cpu_pkg::*;
#(
  parameter int unsigned      DEPTH = 64,
  parameter int unsigned      WAIT  = 2,
  parameter logic [31:0]      NOP   = NOP_INSTR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_addr,
  output logic        resp_err,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Counter starts at WAIT so the response lands in the cycle after edge k+WAIT+1.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT);

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (|(a >> (AW + 2)));
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] resp_addr_q, resp_addr_d;
  logic        resp_err_q, resp_err_d;

  logic        accept;
  logic        rd_fire;
  logic        wr_en;
  logic [31:0] rdata;

  assign req_ready  = (state_q == S_IDLE) || (state_q == S_RESP);
  assign resp_valid = (state_q == S_RESP) && !flush;
  assign accept     = req_valid && req_ready;
  assign rd_fire    = (state_q == S_WAIT) && (cnt_q == '0) && !flush;
  assign wr_en      = prog_we && !addr_bad(prog_addr);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    resp_addr_d = resp_addr_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
          addr_d  = req_addr;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d     = S_RESP;
          resp_addr_d = addr_q;
          resp_err_d  = addr_bad(addr_q);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (accept) begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
          addr_d  = req_addr;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      resp_addr_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      resp_addr_q <= resp_addr_d;
      resp_err_q  <= resp_err_d;
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock_i (clock),
    .reset_i (reset),
    .we_i    (wr_en),
    .waddr_i (prog_addr[AW+1:2]),
    .wdata_i (prog_data),
    .re_i    (rd_fire),
    .raddr_i (addr_q[AW+1:2]),
    .rdata_o (rdata)
  );

  assign resp_instr = resp_err_q ? NOP : rdata;
  assign resp_addr  = resp_addr_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: WAIT=2 instance plus a WAIT=0 instance for collision checks.
module tb_imem_responder;

  logic        clock = 1'b0;
  logic        reset;

  logic        req_valid, flush, prog_we;
  logic [31:0] req_addr, prog_addr, prog_data;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_instr, resp_addr;

  logic        r0_valid, f0, p0_we;
  logic [31:0] r0_addr, p0_addr, p0_data;
  logic        o0_ready, o0_valid, o0_err;
  logic [31:0] o0_instr, o0_addr;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clock = ~clock;

  imem_responder #(.DEPTH(64), .WAIT(2), .NOP(32'h0000_0000)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush),
    .resp_valid(resp_valid), .resp_instr(resp_instr), .resp_addr(resp_addr), .resp_err(resp_err),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  imem_responder #(.DEPTH(64), .WAIT(0), .NOP(32'h0000_0000)) dut0 (
    .clock(clock), .reset(reset),
    .req_valid(r0_valid), .req_addr(r0_addr), .req_ready(o0_ready),
    .flush(f0),
    .resp_valid(o0_valid), .resp_instr(o0_instr), .resp_addr(o0_addr), .resp_err(o0_err),
    .prog_we(p0_we), .prog_addr(p0_addr), .prog_data(p0_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic prog0(input logic [31:0] a, input logic [31:0] d);
    p0_we = 1'b1; p0_addr = a; p0_data = d;
    step();
    p0_we = 1'b0;
  endtask

  // Accept a request on the WAIT=2 instance, then run to its RESP cycle.
  task automatic fetch(input logic [31:0] a);
    req_valid = 1'b1; req_addr = a;
    step();
    req_valid = 1'b0;
    step(3);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    r0_valid = 1'b0; r0_addr = '0; f0 = 1'b0;
    p0_we = 1'b0; p0_addr = '0; p0_data = '0;
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_instr", resp_instr, 32'h0);
    check("rst_addr", resp_addr, 32'h0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    step(2);
    reset = 1'b0;

    // Test 1/2: basic latency and back-to-back
    prog(32'h0, 32'h2001_0005);
    prog(32'h4, 32'h8C22_0004);
    req_valid = 1'b1; req_addr = 32'h0;
    step();                                   // edge k
    req_valid = 1'b0;
    check("t1_busy_ready", {31'd0, req_ready}, 32'd0);
    step(2);
    check("t1_early_valid", {31'd0, resp_valid}, 32'd0);
    step();                                   // edge k+3
    check("t1_valid", {31'd0, resp_valid}, 32'd1);
    check("t1_instr", resp_instr, 32'h2001_0005);
    check("t1_addr", resp_addr, 32'h0);
    check("t1_err", {31'd0, resp_err}, 32'd0);
    check("t1_resp_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = 32'h4;
    step();                                   // accept in RESP
    req_valid = 1'b0;
    check("t2_valid_gap", {31'd0, resp_valid}, 32'd0);
    step(2);
    check("t2_early_valid", {31'd0, resp_valid}, 32'd0);
    step();
    check("t2_valid", {31'd0, resp_valid}, 32'd1);
    check("t2_instr", resp_instr, 32'h8C22_0004);
    check("t2_addr", resp_addr, 32'h4);
    step();
    check("t2_one_cycle", {31'd0, resp_valid}, 32'd0);

    // Test 3: error responses
    fetch(32'h0000_0006);
    check("t3a_valid", {31'd0, resp_valid}, 32'd1);
    check("t3a_err", {31'd0, resp_err}, 32'd1);
    check("t3a_instr", resp_instr, 32'h0);
    check("t3a_addr", resp_addr, 32'h6);
    step();
    fetch(32'h0000_0100);
    check("t3b_valid", {31'd0, resp_valid}, 32'd1);
    check("t3b_err", {31'd0, resp_err}, 32'd1);
    check("t3b_instr", resp_instr, 32'h0);
    check("t3b_addr", resp_addr, 32'h100);
    step();

    // Test 4: flush in WAIT, then flush in RESP with a new request
    prog(32'h18, 32'h1111_1111);
    prog(32'h1C, 32'h2222_2222);
    req_valid = 1'b1; req_addr = 32'h18;
    step();
    req_valid = 1'b0; flush = 1'b1;
    #1;
    check("t4_flush_ready", {31'd0, req_ready}, 32'd0);
    step();
    flush = 1'b0;
    check("t4_post_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("t4_no_resp", {31'd0, resp_valid}, 32'd0);
      step();
    end
    fetch(32'h18);
    check("t4_pre_flush_valid", {31'd0, resp_valid}, 32'd1);
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h1C;
    #1;
    check("t4_resp_suppressed", {31'd0, resp_valid}, 32'd0);
    check("t4_resp_ready", {31'd0, req_ready}, 32'd1);
    step();
    flush = 1'b0; req_valid = 1'b0;
    step(3);
    check("t4b_valid", {31'd0, resp_valid}, 32'd1);
    check("t4b_instr", resp_instr, 32'h2222_2222);
    check("t4b_addr", resp_addr, 32'h1C);
    step();

    // Test 5: asynchronous reset mid-WAIT
    req_valid = 1'b1; req_addr = 32'h4;
    step();
    req_valid = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    check("t5_ready", {31'd0, req_ready}, 32'd1);
    check("t5_instr", resp_instr, 32'h0);
    check("t5_addr", resp_addr, 32'h0);
    check("t5_err", {31'd0, resp_err}, 32'd0);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_no_resp", {31'd0, resp_valid}, 32'd0);
    end

    // Test 6: WAIT=0 instance, ignored bad writes and read-before-write
    prog0(32'h0, 32'h1234_5678);
    prog0(32'h100, 32'hDEAD_BEEF);
    prog0(32'h2, 32'h0000_0BAD);
    r0_valid = 1'b1; r0_addr = 32'h0;
    step();
    r0_valid = 1'b0;
    check("t6_w0_early", {31'd0, o0_valid}, 32'd0);
    step();
    check("t6_w0_valid", {31'd0, o0_valid}, 32'd1);
    check("t6_bad_wr_ignored", o0_instr, 32'h1234_5678);
    step();
    prog0(32'h84, 32'h55AA_55AA);
    r0_valid = 1'b1; r0_addr = 32'h84;
    step();                                   // edge k
    r0_valid = 1'b0;
    p0_we = 1'b1; p0_addr = 32'h84; p0_data = 32'hAC43_0000;
    step();                                   // edge k+1: write collides with read
    p0_we = 1'b0;
    check("t6_coll_valid", {31'd0, o0_valid}, 32'd1);
    check("t6_coll_old", o0_instr, 32'h55AA_55AA);
    check("t6_coll_addr", o0_addr, 32'h84);
    step();
    r0_valid = 1'b1; r0_addr = 32'h84;
    step();
    r0_valid = 1'b0;
    check("t6_refetch_early", {31'd0, o0_valid}, 32'd0);
    step();
    check("t6_refetch_valid", {31'd0, o0_valid}, 32'd1);
    check("t6_refetch_new", o0_instr, 32'hAC43_0000);
    check("t6_refetch_err", {31'd0, o0_err}, 32'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
